scan_mux: RTL and testbench

SCAN_MUX -- requirements
Module: scan_mux

---
 rtl/scan_mux_pkg.sv | 17 +
 rtl/scan_mux_if.sv | 29 ++
 rtl/scan_mux_onehot_dec.sv | 24 ++
 rtl/scan_mux.sv | 101 ++++++++++
 tb/tb_scan_mux.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/scan_mux_pkg.sv
// rtl/scan_mux_pkg.sv - shared types, mode encodings and width helper for scan_mux
package scan_mux_pkg;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Never returns zero so single-value counters still get a legal vector width.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_mux_if.sv
// rtl/scan_mux_if.sv - channel data, control and registered outputs of scan_mux
interface scan_mux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    import scan_mux_pkg::*;

    localparam int CW = cnt_width(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] data_i;
    logic                      mode_i;
    logic [CW-1:0]             sel_i;
    logic                      hold_i;
    logic [WIDTH-1:0]          data_o;
    logic [CW-1:0]             chan_o;
    logic [CHANNELS-1:0]       chan_oh_o;
    logic                      tick_o;

    modport slave (
        input  data_i, mode_i, sel_i, hold_i,
        output data_o, chan_o, chan_oh_o, tick_o
    );

    modport master (
        output data_i, mode_i, sel_i, hold_i,
        input  data_o, chan_o, chan_oh_o, tick_o
    );

endinterface

// File: rtl/scan_mux_onehot_dec.sv
// rtl/scan_mux_onehot_dec.sv - one-hot channel decode with an all-zero blanking enable
module onehot_dec
    import scan_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CW       = cnt_width(CHANNELS)
) (
    input  logic [CW-1:0]       idx,
    input  logic                en,
    output logic [CHANNELS-1:0] oh
);

    always_comb begin
        oh = '0;
        if (en) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (idx == CW'(k)) begin
                    oh[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - manual/auto-scan channel multiplexer with blanking after each change
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 2
) (
    input logic       clk,
    input logic       rst,
    scan_mux_if.slave bus
);

    localparam int CW = cnt_width(CHANNELS);
    localparam int PW = cnt_width(TICK_DIV);

    localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST   = PW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [CW-1:0] CHAN_LAST    = CW'(CHANNELS - 1);
    localparam logic [CW:0]   CHAN_LIM     = (CW + 1)'(CHANNELS);
    localparam state_t        CHANGE_STATE = (BLANK_CYC > 0) ? BLANK : SHOW;

    state_t              state, state_n;
    logic [PW-1:0]       presc, presc_n;
    logic [CW-1:0]       chan, chan_n;
    logic                mode_q;
    logic [CHANNELS-1:0] oh_n;
    logic [WIDTH-1:0]    data_sel;

    always_comb begin
        state_n = state;
        presc_n = presc;
        chan_n  = chan;
        if (bus.mode_i != mode_q) begin
            // Mode switch cycle only restarts the prescaler; the channel carries over.
            presc_n = '0;
        end else if (bus.mode_i == MODE_MANUAL && {1'b0, bus.sel_i} < CHAN_LIM
                     && bus.sel_i != chan) begin
            chan_n  = bus.sel_i;
            state_n = CHANGE_STATE;
            presc_n = '0;
        end else if (state == BLANK) begin
            if (presc == BLANK_LAST) begin
                state_n = SHOW;
                presc_n = '0;
            end else begin
                presc_n = presc + 1'b1;
            end
        end else if (bus.mode_i == MODE_SCAN && !bus.hold_i) begin
            if (presc == PRESC_LAST) begin
                presc_n = '0;
                chan_n  = (chan == CHAN_LAST) ? '0 : chan + 1'b1;
                state_n = CHANGE_STATE;
            end else begin
                presc_n = presc + 1'b1;
            end
        end
    end

    always_comb begin
        data_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (chan == CW'(k)) begin
                data_sel = bus.data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    onehot_dec #(
        .CHANNELS (CHANNELS),
        .CW       (CW)
    ) u_onehot_dec (
        .idx (chan_n),
        .en  (state_n == SHOW),
        .oh  (oh_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SHOW;
            presc         <= '0;
            chan          <= '0;
            mode_q        <= bus.mode_i;
            bus.data_o    <= '0;
            bus.chan_oh_o <= '0;
            bus.tick_o    <= 1'b0;
        end else begin
            state         <= state_n;
            presc         <= presc_n;
            chan          <= chan_n;
            mode_q        <= bus.mode_i;
            bus.data_o    <= data_sel;
            bus.chan_oh_o <= oh_n;
            bus.tick_o    <= (chan_n != chan);
        end
    end

    assign bus.chan_o = chan;

endmodule

// File: tb/tb_scan_mux.sv
// tb/tb_scan_mux.sv - directed self-checking bench for scan_mux (4- and 3-channel builds)
module tb_scan_mux;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    scan_mux_if #(.WIDTH(8), .CHANNELS(4)) bus  ();
    scan_mux_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

    scan_mux #(.WIDTH(8), .CHANNELS(4), .TICK_DIV(4), .BLANK_CYC(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    scan_mux #(.WIDTH(8), .CHANNELS(3), .TICK_DIV(4), .BLANK_CYC(1)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    // Cycle n (1..20) after reset release with mode_i=1; the first edge is the mode switch.
    int exp_chan [20] = '{0,0,0,0,1, 1,1,1,1,2, 2,2,2,2,3, 3,3,3,3,0};
    int exp_tick [20] = '{0,0,0,0,1, 0,0,0,0,1, 0,0,0,0,1, 0,0,0,0,1};
    int exp_oh   [20] = '{1,1,1,1,0, 2,2,2,2,0, 4,4,4,4,0, 8,8,8,8,0};
    int exp_data [20] = '{'h11,'h11,'h11,'h11,'h11, 'h22,'h22,'h22,'h22,'h22,
                          'h33,'h33,'h33,'h33,'h33, 'h44,'h44,'h44,'h44,'h44};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int  ticks;
    bit  found;

    initial begin
        rst          = 1'b1;
        bus.data_i   = 32'h44332211;
        bus.mode_i   = 1'b0;
        bus.sel_i    = 2'd0;
        bus.hold_i   = 1'b0;
        bus3.data_i  = 24'h332211;
        bus3.mode_i  = 1'b0;
        bus3.sel_i   = 2'd0;
        bus3.hold_i  = 1'b0;
        step();
        step();
        check("rst_data", 32'(bus.data_o), 32'h0);
        check("rst_chan", 32'(bus.chan_o), 32'h0);
        check("rst_oh",   32'(bus.chan_oh_o), 32'h0);
        check("rst_tick", 32'(bus.tick_o), 32'h0);

        rst        = 1'b0;
        bus.mode_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("scan_chan%0d", i + 1), 32'(bus.chan_o), 32'(exp_chan[i]));
            check($sformatf("scan_tick%0d", i + 1), 32'(bus.tick_o), 32'(exp_tick[i]));
            check($sformatf("scan_oh%0d",   i + 1), 32'(bus.chan_oh_o), 32'(exp_oh[i]));
            check($sformatf("scan_data%0d", i + 1), 32'(bus.data_o), 32'(exp_data[i]));
        end

        // Advance to ch2 with two prescaler counts already taken, then hold.
        for (int i = 0; i < 13; i++) step();
        check("pre_hold_chan", 32'(bus.chan_o), 32'd2);
        check("pre_hold_oh",   32'(bus.chan_oh_o), 32'h4);
        bus.hold_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("hold_chan%0d", i), 32'(bus.chan_o), 32'd2);
            check($sformatf("hold_tick%0d", i), 32'(bus.tick_o), 32'd0);
            check($sformatf("hold_oh%0d", i),   32'(bus.chan_oh_o), 32'h4);
        end
        bus.hold_i = 1'b0;
        step();
        check("release_chan1", 32'(bus.chan_o), 32'd2);
        check("release_tick1", 32'(bus.tick_o), 32'd0);
        step();
        check("release_chan2", 32'(bus.chan_o), 32'd3);
        check("release_tick2", 32'(bus.tick_o), 32'd1);

        // Manual mode: settle on ch0, then request ch3.
        bus.mode_i = 1'b0;
        bus.sel_i  = 2'd0;
        for (int i = 0; i < 4; i++) step();
        check("man0_chan", 32'(bus.chan_o), 32'd0);
        check("man0_oh",   32'(bus.chan_oh_o), 32'h1);
        check("man0_data", 32'(bus.data_o), 32'h11);
        bus.sel_i = 2'd3;
        step();
        check("man3_chan", 32'(bus.chan_o), 32'd3);
        check("man3_tick", 32'(bus.tick_o), 32'd1);
        check("man3_oh_blank", 32'(bus.chan_oh_o), 32'h0);
        step();
        check("man3_oh",   32'(bus.chan_oh_o), 32'h8);
        check("man3_data", 32'(bus.data_o), 32'h44);
        check("man3_tick_done", 32'(bus.tick_o), 32'd0);

        // Held select produces exactly one tick.
        bus.sel_i = 2'd1;
        ticks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.tick_o) ticks++;
            if (i > 0) check($sformatf("man1_oh%0d", i), 32'(bus.chan_oh_o), 32'h2);
        end
        check("man1_ticks", 32'(ticks), 32'd1);
        check("man1_chan",  32'(bus.chan_o), 32'd1);

        // Scan through the 3->0 wrap and reset inside the following blank.
        bus.sel_i = 2'd3;
        step();
        step();
        bus.mode_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (bus.tick_o) found = 1'b1;
        end
        check("wrap_tick_seen", 32'(found), 32'd1);
        check("wrap_chan",      32'(bus.chan_o), 32'd0);
        check("wrap_oh_blank",  32'(bus.chan_oh_o), 32'h0);
        rst = 1'b1;
        step();
        check("midrst_data", 32'(bus.data_o), 32'h0);
        check("midrst_chan", 32'(bus.chan_o), 32'h0);
        check("midrst_oh",   32'(bus.chan_oh_o), 32'h0);
        check("midrst_tick", 32'(bus.tick_o), 32'h0);
        rst = 1'b0;
        step();
        check("postrst_oh",   32'(bus.chan_oh_o), 32'h1);
        check("postrst_data", 32'(bus.data_o), 32'h11);
        check("postrst_tick", 32'(bus.tick_o), 32'h0);

        // Three-channel build: out-of-range select is ignored, legal one is taken.
        bus3.sel_i = 2'd3;
        ticks = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus3.tick_o) ticks++;
        end
        check("ch3_oor_ticks", 32'(ticks), 32'd0);
        check("ch3_oor_chan",  32'(bus3.chan_o), 32'd0);
        check("ch3_oor_oh",    32'(bus3.chan_oh_o), 32'h1);
        bus3.sel_i = 2'd2;
        step();
        check("ch3_sel2_chan", 32'(bus3.chan_o), 32'd2);
        check("ch3_sel2_tick", 32'(bus3.tick_o), 32'd1);
        step();
        check("ch3_sel2_oh",   32'(bus3.chan_oh_o), 32'h4);
        check("ch3_sel2_data", 32'(bus3.data_o), 32'h33);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
